cache_mem_arb: RTL and testbench
================================

// Module: cache_mem_arb
// PURPOSE
//  Sits downstream of cache_ctrl: serves I-cache line fills, D-cache line fills and D-cache
//  writebacks over the single word-wide main-memory port. Per request, bursts LINE_WORDS
//  word commands, assembles the returned line and pulses the matching done strobe.
//  One transaction in flight at a time.
// PARAMETERS
//  LINE_WORDS  16  words per cache line (power of 2, >=2)
//  ADDR_W      32  byte-address width
// PORTS
//  clk          in   1              clock, all state on posedge
//  rst_n        in   1              asynchronous active-low reset
//  i_fill_req   in   1              I-cache line fill request (level, held until i_fill_done)
//  i_fill_addr  in   ADDR_W         I fill byte address (offset bits ignored)
//  d_fill_req   in   1              D-cache line fill request (level)
//  d_fill_addr  in   ADDR_W         D fill byte address
//  d_wb_req     in   1              D-cache dirty-line writeback request (level)
//  d_wb_addr    in   ADDR_W         writeback byte address
//  d_wb_data    in   32*LINE_WORDS  writeback line, word k at [32k+31:32k]
//  fill_data    out  32*LINE_WORDS  assembled fill line, word k at [32k+31:32k]
//  i_fill_done  out  1              1-cycle pulse: fill_data valid for I request
//  d_fill_done  out  1              1-cycle pulse: fill_data valid for D request
//  d_wb_done    out  1              1-cycle pulse: last writeback word accepted
//  mem_addr     out  ADDR_W         word byte address of current command
//  mem_rd       out  1              read command valid
//  mem_wr       out  1              write command valid
//  mem_wdata    out  32             write data
//  mem_rdy      in   1              memory accepts command this cycle (cmd & rdy = accepted)
//  mem_rdata    in   32             read return data
//  mem_rvld     in   1              read data valid; returns in command order, latency >=1
//  busy         out  1              transaction in flight (state != IDLE)
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, fill_data 0, all done pulses/mem_rd/mem_wr/busy 0, mem_addr 0.
//  - FSM: IDLE -> RD (fill) | WR (writeback); RD -> DONE when rcv_cnt hits LINE_WORDS;
//    WR -> DONE when last write accepted; DONE -> IDLE (done pulse asserted in DONE, 1 cycle).
//  - Grant sampled in IDLE only; latch requester ID and line base = addr & ~(LINE_WORDS*4-1).
//    Priority: d_wb_req > d_fill_req > i_fill_req (writeback before refill of same set).
//  - Word k address = line_base + 4k; commands issued k=0..LINE_WORDS-1, in order.
//  - RD: mem_rd=1 while iss_cnt<LINE_WORDS; iss_cnt++ on mem_rd&mem_rdy. rcv_cnt++ on mem_rvld;
//    mem_rdata written to fill_data word rcv_cnt. Issue and return may overlap same cycle.
//  - mem_rvld outside RD, or beyond LINE_WORDS returns, is ignored.
//  - WR: mem_wr=1, mem_wdata=d_wb_data word iss_cnt; d_wb_data sampled live (D-cache holds stable).
//  - mem_rdy low stalls: command and address held unchanged until accepted.
//  - Latency (mem_rdy=1, rvld 1 cycle after accept): fill done = LINE_WORDS+2 cycles after grant.
//  - Requests dropped mid-transaction do not abort; transaction completes, pulse still issued.
//  - Request already granted must deassert in the cycle after its done pulse, else re-served.
//  - fill_data holds last line until next RD begins returning data.
//  - Async reset mid-burst: immediate return to reset state; partial line discarded.
//  - Counters are $clog2(LINE_WORDS)+1 bits; no wrap within a transaction.
// CONFIGURATION
//  CACHE_ARB_RR_EN defined: fill arbitration round-robin between I and D fills (last-served
//    flag, reset to I-served so D wins first tie); d_wb_req keeps absolute priority.
//  Not defined: fixed priority above, I fill may starve under continuous D traffic.
// TESTING
//  1 I fill, addr 0x0000_1034, mem returns 0x100+k -> cmds 0x1000..0x103C, fill_data word k
//    =0x100+k, i_fill_done one pulse at cycle 18 after grant.
//  2 d_wb_req+d_fill_req+i_fill_req same cycle -> order wb, D fill, I fill; 3 done pulses.
//  3 mem_rdy low 3 cycles at word 5 of writeback -> mem_addr/mem_wdata stable; 16 writes total.
//  4 Random rvld latency 1-8 cycles -> fill_data exact, no lost/duplicate words.
//  5 rst_n low at word 7 of fill -> outputs 0 at once; next fill restarts at word 0.
//  6 CACHE_ARB_RR_EN, I and D fills held continuously -> grants alternate D,I,D,I.

Source files
------------

// File: rtl/cache_mem_arb.sv
// Memory-side arbiter: serves I-fill, D-fill and D-writeback line transfers over one word-wide port.
// Optional: define CACHE_ARB_RR_EN to round-robin I and D fills; writeback always keeps top priority.
module cache_mem_arb #(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_fill_req,
    input  logic [ADDR_W-1:0]        i_fill_addr,
    input  logic                     d_fill_req,
    input  logic [ADDR_W-1:0]        d_fill_addr,
    input  logic                     d_wb_req,
    input  logic [ADDR_W-1:0]        d_wb_addr,
    input  logic [32*LINE_WORDS-1:0] d_wb_data,
    output logic [32*LINE_WORDS-1:0] fill_data,
    output logic                     i_fill_done,
    output logic                     d_fill_done,
    output logic                     d_wb_done,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_rdy,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_rvld,
    output logic                     busy
);
    localparam int                IDX_W    = $clog2(LINE_WORDS);
    localparam int                CNT_W    = IDX_W + 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(LINE_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;
    typedef enum logic [1:0] {REQ_I, REQ_D, REQ_WB} req_t;

    state_t                  r_state;
    req_t                    r_req;
    logic [CNT_W-1:0]        r_iss_cnt;
    logic [CNT_W-1:0]        r_rcv_cnt;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic                    r_mem_rd;
    logic                    r_mem_wr;
    logic                    r_i_done;
    logic                    r_d_done;
    logic                    r_wb_done;
    logic [32*LINE_WORDS-1:0] r_fill_data;

    logic                    w_any_req;
    logic                    w_pick_d;
    logic                    w_rd_take;
    logic [ADDR_W-1:0]       w_req_addr;
    logic [ADDR_W-1:0]       w_line_base;
    logic [IDX_W-1:0]        w_iss_idx;
    logic [IDX_W-1:0]        w_rcv_idx;

`ifdef CACHE_ARB_RR_EN
    logic r_last_i;

    // On an I/D tie, D wins only if I was served last.
    assign w_pick_d = d_fill_req && (!i_fill_req || r_last_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_i <= 1'b1;
        end else if (r_state == ST_IDLE && !d_wb_req && (d_fill_req || i_fill_req)) begin
            r_last_i <= !w_pick_d;
        end
    end
`else
    assign w_pick_d = d_fill_req;
`endif

    assign w_any_req   = d_wb_req | d_fill_req | i_fill_req;
    assign w_req_addr  = d_wb_req ? d_wb_addr : (w_pick_d ? d_fill_addr : i_fill_addr);
    assign w_line_base = w_req_addr & ~OFF_MASK;
    assign w_iss_idx   = r_iss_cnt[IDX_W-1:0];
    assign w_rcv_idx   = r_rcv_cnt[IDX_W-1:0];
    // Returns outside RD, or after the line is complete, are dropped.
    assign w_rd_take   = (r_state == ST_RD) && mem_rvld && (r_rcv_cnt != CNT_FULL);

    // NOTE: every state register is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= REQ_I;
            r_iss_cnt  <= '0;
            r_rcv_cnt  <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_i_done   <= 1'b0;
            r_d_done   <= 1'b0;
            r_wb_done  <= 1'b0;
        end else begin
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_wb_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_iss_cnt  <= '0;
                        r_rcv_cnt  <= '0;
                        r_mem_addr <= w_line_base;
                        if (d_wb_req) begin
                            r_req    <= REQ_WB;
                            r_mem_wr <= 1'b1;
                            r_state  <= ST_WR;
                        end else begin
                            r_req    <= w_pick_d ? REQ_D : REQ_I;
                            r_mem_rd <= 1'b1;
                            r_state  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_mem_rd && mem_rdy) begin
                        r_iss_cnt  <= r_iss_cnt + 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(4);
                        if (r_iss_cnt == CNT_LAST) r_mem_rd <= 1'b0;
                    end
                    if (w_rd_take) r_rcv_cnt <= r_rcv_cnt + 1'b1;
                    if (r_rcv_cnt == CNT_FULL) begin
                        r_state  <= ST_DONE;
                        r_i_done <= (r_req == REQ_I);
                        r_d_done <= (r_req == REQ_D);
                    end
                end
                ST_WR: begin
                    if (r_mem_wr && mem_rdy) begin
                        r_iss_cnt  <= r_iss_cnt + 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(4);
                        if (r_iss_cnt == CNT_LAST) begin
                            r_mem_wr  <= 1'b0;
                            r_wb_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the line buffer is a plain register, so it is reset along with the FSM and reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_data <= '0;
        end else if (w_rd_take) begin
            r_fill_data[w_rcv_idx*32 +: 32] <= mem_rdata;
        end
    end

    assign fill_data   = r_fill_data;
    assign i_fill_done = r_i_done;
    assign d_fill_done = r_d_done;
    assign d_wb_done   = r_wb_done;
    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    // Writeback data is taken live; the D-cache holds the line stable until d_wb_done.
    assign mem_wdata   = d_wb_data[w_iss_idx*32 +: 32];
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cache_mem_arb.sv
// Scoreboard bench for cache_mem_arb: directed transactions push expected commands and done events,
// a negedge monitor pops and compares; a behavioural memory supplies in-order read returns.
module tb_cache_mem_arb;
    localparam int LW = 16;
    localparam int AW = 32;

    typedef enum logic [1:0] {K_I, K_D, K_WB} kind_e;
    typedef struct { kind_e kind; logic [31:0] base; } done_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } cmd_t;
    typedef struct { int ready; logic [31:0] data; } ret_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_fill_req = 1'b0;
    logic [AW-1:0]     i_fill_addr = '0;
    logic              d_fill_req = 1'b0;
    logic [AW-1:0]     d_fill_addr = '0;
    logic              d_wb_req = 1'b0;
    logic [AW-1:0]     d_wb_addr = '0;
    logic [32*LW-1:0]  d_wb_data = '0;
    logic [32*LW-1:0]  fill_data;
    logic              i_fill_done, d_fill_done, d_wb_done;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd, mem_wr;
    logic [31:0]       mem_wdata;
    logic              mem_rdy = 1'b1;
    logic [31:0]       mem_rdata = '0;
    logic              mem_rvld = 1'b0;
    logic              busy;

    cache_mem_arb #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr),
        .d_fill_req(d_fill_req), .d_fill_addr(d_fill_addr),
        .d_wb_req(d_wb_req), .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
        .fill_data(fill_data),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wb_done(d_wb_done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_rvld(mem_rvld),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory contents: word at address a reads (a>>2) - 0x300, so line 0x1000 returns 0x100+k.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) - 32'h300;
    endfunction

    function automatic logic [31:0] wb_word(input int k);
        return 32'hCAFE_0000 + 32'(k) * 32'h11;
    endfunction

    function automatic logic [32*LW-1:0] exp_line(input logic [31:0] base);
        logic [32*LW-1:0] l;
        for (int k = 0; k < LW; k++) l[k*32 +: 32] = mem_word(base + 32'(4 * k));
        return l;
    endfunction

    done_t exp_done[$];
    cmd_t  exp_cmd[$];
    ret_t  rq[$];

    int          lat_max    = 1;
    logic        junk_en    = 1'b0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_cnt  = 0;
    int          hold_cnt   = 0;
    int          n_done     = 0;
    int          n_wr       = 0;
    int          last_lat   = 0;

    // Behavioural memory: drives rdy/rvld just after each posedge; returns stay in command order.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            rq.delete();
            mem_rdy   = 1'b1;
            mem_rvld  = 1'b0;
            mem_rdata = '0;
        end else begin
            mem_rdy = 1'b1;
            if (mem_wr && mem_addr == stall_addr && stall_cnt < 3) begin
                mem_rdy = 1'b0;
                stall_cnt++;
            end
            if (mem_rd && mem_rdy)
                rq.push_back('{cyc + int'($urandom_range(lat_max, 1)), mem_word(mem_addr)});
            mem_rvld  = 1'b0;
            mem_rdata = '0;
            if (rq.size() > 0 && rq[0].ready <= cyc) begin
                mem_rvld  = 1'b1;
                mem_rdata = rq[0].data;
                void'(rq.pop_front());
            end else if (junk_en) begin
                mem_rvld  = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted command and every done pulse.
    int          grant_cyc  = 0;
    logic        prev_busy  = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_done.delete();
            exp_cmd.delete();
            prev_busy  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (busy && !prev_busy) grant_cyc = cyc;
            prev_busy = busy;
            if (prev_stall) begin
                check("stall_hold_wr", mem_wr, 1'b1);
                check("stall_hold_addr", mem_addr, prev_addr);
                check("stall_hold_wdata", mem_wdata, prev_wdata);
            end
            prev_stall = mem_wr && !mem_rdy;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;

            if ((mem_rd || mem_wr) && mem_rdy) begin
                if (mem_wr) n_wr++;
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", exp_cmd.size(), 1);
                end else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    check("cmd_dir_wr", mem_wr, c.wr);
                    check("cmd_addr", mem_addr, c.addr);
                    if (c.wr) check("cmd_wdata", mem_wdata, c.data);
                end
            end

            if (i_fill_done || d_fill_done || d_wb_done) begin
                kind_e got;
                got      = i_fill_done ? K_I : (d_fill_done ? K_D : K_WB);
                last_lat = cyc - grant_cyc;
                n_done++;
                check("done_onehot", 32'(i_fill_done) + 32'(d_fill_done) + 32'(d_wb_done), 1);
                if (exp_done.size() == 0) begin
                    check("done_unexpected", exp_done.size(), 1);
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("done_kind", got, e.kind);
                    if (e.kind != K_WB) check("fill_line", fill_data, exp_line(e.base));
                end
            end
        end
    end

    task automatic expect_txn(input kind_e k, input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~32'h3F;
        exp_done.push_back('{k, base});
        for (int w = 0; w < LW; w++)
            exp_cmd.push_back('{k == K_WB, base + 32'(4 * w), (k == K_WB) ? wb_word(w) : 32'h0});
    endtask

    // Plays the cache side: drops a served request in its done cycle unless still being held.
    task automatic wait_idle(input int budget);
        int  n = 0;
        bit  idle = 1'b0;
        while (n < budget && !idle) begin
            @(posedge clk);
            #1;
            n++;
            if (i_fill_done || d_fill_done || d_wb_done) begin
                if (hold_cnt > 1) begin
                    hold_cnt--;
                end else begin
                    hold_cnt = 0;
                    if (i_fill_done) i_fill_req = 1'b0;
                    if (d_fill_done) d_fill_req = 1'b0;
                    if (d_wb_done)   d_wb_req   = 1'b0;
                end
            end
            if (exp_done.size() == 0 && !busy && !(i_fill_req || d_fill_req || d_wb_req)) idle = 1'b1;
        end
        check("drain_exp_done", exp_done.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        int n0;
        int w0;
        for (int k = 0; k < LW; k++) d_wb_data[k*32 +: 32] = wb_word(k);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_fill_data", fill_data, '0);
        check("rst_dones", {i_fill_done, d_fill_done, d_wb_done}, 3'b000);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single I fill: commands 0x1000..0x103C, line 0x100+k, done 18 cycles after grant.
        expect_txn(K_I, 32'h0000_1034);
        i_fill_addr = 32'h0000_1034;
        i_fill_req  = 1'b1;
        wait_idle(200);
        check("t1_latency", last_lat, 18);
        check("t1_word0", fill_data[31:0], 32'h100);
        check("t1_word15", fill_data[32*LW-1 -: 32], 32'h10F);

        // Stray returns while idle must not touch the held line.
        junk_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        junk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_rvld_word0", fill_data[31:0], 32'h100);
        check("idle_rvld_busy", busy, 1'b0);

        // All three requesters at once: writeback, then D fill, then I fill.
        expect_txn(K_WB, 32'h0000_2040);
        expect_txn(K_D,  32'h0000_3008);
        expect_txn(K_I,  32'h0000_4010);
        n0 = n_done;
        d_wb_addr   = 32'h0000_2040;
        d_fill_addr = 32'h0000_3008;
        i_fill_addr = 32'h0000_4010;
        d_wb_req    = 1'b1;
        d_fill_req  = 1'b1;
        i_fill_req  = 1'b1;
        wait_idle(500);
        check("t2_done_count", n_done - n0, 3);

        // Writeback with a 3-cycle stall on word 5.
        expect_txn(K_WB, 32'h0000_5080);
        stall_addr = 32'h0000_5080 + 32'd20;
        w0 = n_wr;
        d_wb_addr = 32'h0000_5080;
        d_wb_req  = 1'b1;
        wait_idle(300);
        check("t3_writes", n_wr - w0, 16);
        check("t3_stall_cycles", stall_cnt, 3);
        check("t3_latency", last_lat, 19);

        // Random read latency 1..8 on a D fill and an I fill.
        lat_max = 8;
        expect_txn(K_D, 32'h0000_2A7C);
        d_fill_addr = 32'h0000_2A7C;
        d_fill_req  = 1'b1;
        wait_idle(1000);
        expect_txn(K_I, 32'h0001_23C4);
        i_fill_addr = 32'h0001_23C4;
        i_fill_req  = 1'b1;
        wait_idle(1000);
        lat_max = 1;

        // Reset while word 7 of a fill is being issued.
        expect_txn(K_I, 32'h0000_6000);
        i_fill_addr = 32'h0000_6000;
        i_fill_req  = 1'b1;
        for (int n = 0; n < 100 && !(mem_rd && mem_addr == 32'h0000_601C); n++) begin
            @(posedge clk);
            #1;
        end
        check("t5_reached_word7", mem_addr, 32'h0000_601C);
        rst_n      = 1'b0;
        i_fill_req = 1'b0;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_mem_rd", mem_rd, 1'b0);
        check("t5_rst_mem_addr", mem_addr, 32'h0);
        check("t5_rst_fill_data", fill_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_txn(K_I, 32'h0000_6000);
        i_fill_req = 1'b1;
        wait_idle(200);
        check("t5_refill_latency", last_lat, 18);

        // I and D fills held together.
`ifdef CACHE_ARB_RR_EN
        expect_txn(K_D, 32'h0000_7000);
        expect_txn(K_I, 32'h0000_8000);
        expect_txn(K_D, 32'h0000_7000);
        expect_txn(K_I, 32'h0000_8000);
        expect_txn(K_D, 32'h0000_7000);
        hold_cnt = 4;
`else
        expect_txn(K_D, 32'h0000_7000);
        expect_txn(K_D, 32'h0000_7000);
        expect_txn(K_D, 32'h0000_7000);
        expect_txn(K_I, 32'h0000_8000);
        hold_cnt = 3;
`endif
        d_fill_addr = 32'h0000_7000;
        i_fill_addr = 32'h0000_8000;
        d_fill_req  = 1'b1;
        i_fill_req  = 1'b1;
        wait_idle(2000);

        check("final_cmd_queue", exp_cmd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
